nfc_command_feature: RTL and testbench
======================================

Name: nfc_command_feature

Overview:
- Parametrised SET FEATURES (EFh) / GET FEATURES (EEh) command executor. Sits between the NFC command dispatcher and the atomic command generator (ACG) layer.
- Feature address and parameter words are supplied per command; nothing is hard-coded.
- Adds a GET path with read-data capture, a configurable parameter length, and an RB-low watchdog so a missed busy pulse cannot hang the FSM.

Parameters:
- NumberOfWays, 4, number of NAND ways; width of way masks.
- SetCommandID, 6'b000010, opcode that launches SET FEATURES.
- GetCommandID, 6'b000011, opcode that launches GET FEATURES.
- ParamWords, 2, number of 16-bit parameter words per feature (bytes = 2*ParamWords).
- RBLowTimeout, 64, cycles to wait for busy assertion before treating it as already elapsed.

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iOpcode  in  6  command opcode
- iCMDValid  in  1  command valid
- oCMDReady  out  1  block idle, accepting commands
- iWaySelect  in  NumberOfWays  target way mask, latched on accept
- iFeatureAddr  in  8  feature address, latched on accept
- iFeatureData  in  16*ParamWords  SET parameters, word 0 in MSBs, latched on accept
- oFeatureData  out  16*ParamWords  GET result, word 0 in MSBs
- oFeatureValid  out  1  one-cycle pulse: oFeatureData updated
- oStart  out  1  combinational: opcode matches either ID & iCMDValid
- oLastStep  out  1  one-cycle pulse at command completion
- oACG_Command  out  8  one-hot ACG request: [6]=CA issue, [5]=data out, [4]=data in
- oACG_CommandOption  out  3  always 0
- iACG_Ready  in  8  ACG engine ready flags
- iACG_LastStep  in  8  ACG engine done pulses, same bit map as oACG_Command
- oACG_TargetWay  out  NumberOfWays  latched way mask
- oACG_NumOfData  out  16  cycle count / byte count for current step
- oACG_CASelect  out  1  1=command latch, 0=address latch
- oACG_CAData  out  40  CA bytes, first byte in [39:32]
- oACG_WriteData  out  16  parameter word stream
- oACG_WriteLast  out  1  final word marker
- oACG_WriteValid  out  1  write word valid
- iACG_WriteReady  in  1  write word accepted
- iACG_ReadData  in  16  read word
- iACG_ReadLast  in  1  final read word
- iACG_ReadValid  in  1  read word valid
- oACG_ReadReady  out  1  read word ready
- iACG_ReadyBusy  in  NumberOfWays  per-way R/B# (1=ready)

Behaviour:
- Reset values:
  - oCMDReady=1.
  - oLastStep, oFeatureValid, oACG_WriteValid, oACG_WriteLast, oACG_ReadReady = 0.
  - oACG_Command=0, oACG_TargetWay=0, oACG_NumOfData=0, oACG_CASelect=1, oACG_CAData=0.
  - oFeatureData=0; FSM in RESET. Next cycle goes to READY.
- Accept: in READY with oStart=1, latch mode (get = opcode==GetCommandID), iWaySelect, iFeatureAddr, iFeatureData; go to CMDIssue. oCMDReady=0 from the next cycle until READY is re-entered.
- Issue-step rule (CMDIssue, ADDRIssue, DATAOut, DATAIn):
  - ACG ready = iACG_Ready[6:0]==7'h7F.
  - The step's command bit is driven while an internal "launched" flag is 0. The flag sets on the first cycle the bit is high and the ACG is ready; the bit then drops.
  - The step completes on its iACG_LastStep bit with launched=1. The flag clears on state entry.
  - A LastStep pulse seen before launch is ignored.
- CMDIssue: CASelect=1, NumOfData=1, CAData={set?8'hEF:8'hEE,32'h0}, bit 6. Done -> ADDRIssue.
- ADDRIssue: CASelect=0, NumOfData=1, CAData={featureAddr,32'h0}, bit 6. Done -> DATAOut (set) or WaitRBLow (get).
- DATAOut: bit 5, NumOfData=2*ParamWords.
  - Word k is presented on WriteData with WriteValid=1; it advances on Valid&Ready.
  - WriteLast=1 only on word ParamWords-1; WriteValid=0 after the last handshake.
  - Stalls of iACG_WriteReady hold data stable.
  - Done (bit-5 LastStep) -> WaitRBLow.
- R/B sampling: two-register pipeline: reg1 <= TargetWay & iACG_ReadyBusy; wayRB <= |reg1 (2-cycle latency).
- WaitRBLow: counter cleared on entry.
  - Goes to WaitRBHigh when wayRB==0.
  - Also goes to WaitRBHigh when the counter reaches RBLowTimeout-1 (missed busy).
- WaitRBHigh: when wayRB==1 -> DONE (set) or DATAIn (get).
- DATAIn: bit 4, NumOfData=2*ParamWords, ReadReady=1.
  - Each Valid&Ready word is shifted into a capture register, word 0 ending in the MSBs.
  - On the final word (count==ParamWords-1 or ReadLast): drive oFeatureData and pulse oFeatureValid for one cycle. Extra words are dropped.
  - Done (bit-4 LastStep) -> DONE.
- DONE: oLastStep=1 for one cycle -> READY.
- oACG_TargetWay holds the latched mask from accept until READY is re-entered.
- iReset mid-command forces all outputs to reset values on the next edge. No partial ACG request persists.
- Opcodes other than the two IDs are ignored. oStart may assert while busy but has no effect outside READY.

Test Plan:
- SET, addr 8'h01, data 32'h1400_0000, ParamWords=2:
  - CAData EF00000000 then 0100000000.
  - Write words 16'h1400 then 16'h0000 (Last on the second).
  - Then RB low/high, oLastStep pulse; total one oLastStep.
- GET, addr 8'h80: CA EE/80, RB cycle, read words 16'hABCD, 16'h1234 -> oFeatureData=32'hABCD_1234 with a single oFeatureValid pulse, then oLastStep.
- SET with iACG_WriteReady low 5 cycles mid-stream -> WriteData/WriteLast stable during the stall; exactly 2 handshakes.
- R/B never drops -> FSM leaves WaitRBLow after 64 cycles and completes with oLastStep.
- iReset asserted during DATAOut -> next cycle oACG_Command=0, WriteValid=0, oCMDReady=1 after READY; a new SET then runs cleanly.
- Opcode 6'b000111 with iCMDValid=1 -> oStart=0, FSM stays READY, no ACG activity.

Source files
------------

// File: rtl/nfc_command_feature_if.sv
`timescale 1ns/1ps
// ACG-side bus of the feature command executor: request/CA lines, write and read
// word streams, and per-way ready/busy. master = command executor, slave = ACG layer.
interface nfc_command_feature_if #(
    parameter int NumberOfWays = 4
) ();
    logic [7:0]              oACG_Command;
    logic [2:0]              oACG_CommandOption;
    logic [7:0]              iACG_Ready;
    logic [7:0]              iACG_LastStep;
    logic [NumberOfWays-1:0] oACG_TargetWay;
    logic [15:0]             oACG_NumOfData;
    logic                    oACG_CASelect;
    logic [39:0]             oACG_CAData;
    logic [15:0]             oACG_WriteData;
    logic                    oACG_WriteLast;
    logic                    oACG_WriteValid;
    logic                    iACG_WriteReady;
    logic [15:0]             iACG_ReadData;
    logic                    iACG_ReadLast;
    logic                    iACG_ReadValid;
    logic                    oACG_ReadReady;
    logic [NumberOfWays-1:0] iACG_ReadyBusy;

    modport master (
        output oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
               oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast,
               oACG_WriteValid, oACG_ReadReady,
        input  iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadData,
               iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy
    );

    modport slave (
        input  oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
               oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast,
               oACG_WriteValid, oACG_ReadReady,
        output iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadData,
               iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy
    );
endinterface

// File: rtl/nfc_command_feature.sv
`timescale 1ns/1ps
// SET FEATURES (EFh) / GET FEATURES (EEh) executor sitting between the NFC dispatcher
// and the ACG layer: CA issue, address, optional data out, R/B wait, optional data in.
module nfc_command_feature #(
    parameter int          NumberOfWays = 4,
    parameter logic [5:0]  SetCommandID = 6'b000010,
    parameter logic [5:0]  GetCommandID = 6'b000011,
    parameter int          ParamWords   = 2,
    parameter int          RBLowTimeout = 64
) (
    input  logic                      iSystemClock,
    input  logic                      iReset,
    input  logic [5:0]                iOpcode,
    input  logic                      iCMDValid,
    output logic                      oCMDReady,
    input  logic [NumberOfWays-1:0]   iWaySelect,
    input  logic [7:0]                iFeatureAddr,
    input  logic [16*ParamWords-1:0]  iFeatureData,
    output logic [16*ParamWords-1:0]  oFeatureData,
    output logic                      oFeatureValid,
    output logic                      oStart,
    output logic                      oLastStep,
    nfc_command_feature_if.master     acg
);

    localparam int DataW = 16 * ParamWords;
    localparam int CntW  = (ParamWords > 1) ? $clog2(ParamWords) : 1;
    localparam int RbW   = $clog2(RBLowTimeout + 1);

    typedef enum logic [3:0] {
        S_RESET,
        S_READY,
        S_CMD_ISSUE,
        S_ADDR_ISSUE,
        S_DATA_OUT,
        S_WAIT_RB_LOW,
        S_WAIT_RB_HIGH,
        S_DATA_IN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    get_mode_q, get_mode_d;
    logic [7:0]              feature_addr_q, feature_addr_d;
    logic [DataW-1:0]        wdata_sr_q, wdata_sr_d;
    logic [CntW-1:0]         word_cnt_q, word_cnt_d;
    logic                    launched_q, launched_d;
    logic [RbW-1:0]          rb_cnt_q, rb_cnt_d;
    logic [NumberOfWays-1:0] rb_sample_q, rb_sample_d;
    logic                    way_rb_q, way_rb_d;
    logic [DataW-1:0]        capture_q, capture_d;
    logic                    captured_q, captured_d;
    logic [DataW-1:0]        feature_data_q, feature_data_d;
    logic                    feature_valid_q, feature_valid_d;
    logic                    last_step_q, last_step_d;
    logic [7:0]              acg_command_q, acg_command_d;
    logic [NumberOfWays-1:0] target_way_q, target_way_d;
    logic [15:0]             num_of_data_q, num_of_data_d;
    logic                    ca_select_q, ca_select_d;
    logic [39:0]             ca_data_q, ca_data_d;
    logic                    write_valid_q, write_valid_d;
    logic                    write_last_q, write_last_d;
    logic                    read_ready_q, read_ready_d;

    logic                    acg_ready;
    logic [7:0]              step_mask;
    logic                    step_done;
    logic [DataW-1:0]        capture_shift;
    logic                    unused_acg_bits;

    assign oStart        = iCMDValid && ((iOpcode == SetCommandID) || (iOpcode == GetCommandID));
    assign acg_ready     = (acg.iACG_Ready[6:0] == 7'h7F);
    assign capture_shift = (capture_q << 16) | DataW'(acg.iACG_ReadData);
    assign unused_acg_bits = acg.iACG_Ready[7];

    assign oCMDReady              = cmd_ready_q;
    assign oFeatureData           = feature_data_q;
    assign oFeatureValid          = feature_valid_q;
    assign oLastStep              = last_step_q;
    assign acg.oACG_Command       = acg_command_q;
    assign acg.oACG_CommandOption = 3'b000;
    assign acg.oACG_TargetWay     = target_way_q;
    assign acg.oACG_NumOfData     = num_of_data_q;
    assign acg.oACG_CASelect      = ca_select_q;
    assign acg.oACG_CAData        = ca_data_q;
    assign acg.oACG_WriteData     = wdata_sr_q[DataW-1 -: 16];
    assign acg.oACG_WriteLast     = write_last_q;
    assign acg.oACG_WriteValid    = write_valid_q;
    assign acg.oACG_ReadReady     = read_ready_q;

    always_comb begin
        state_d         = state_q;
        cmd_ready_d     = cmd_ready_q;
        get_mode_d      = get_mode_q;
        feature_addr_d  = feature_addr_q;
        wdata_sr_d      = wdata_sr_q;
        word_cnt_d      = word_cnt_q;
        launched_d      = launched_q;
        rb_cnt_d        = rb_cnt_q;
        rb_sample_d     = target_way_q & acg.iACG_ReadyBusy;
        way_rb_d        = |rb_sample_q;
        capture_d       = capture_q;
        captured_d      = captured_q;
        feature_data_d  = feature_data_q;
        feature_valid_d = 1'b0;
        last_step_d     = 1'b0;
        acg_command_d   = acg_command_q;
        target_way_d    = target_way_q;
        num_of_data_d   = num_of_data_q;
        ca_select_d     = ca_select_q;
        ca_data_d       = ca_data_q;
        write_valid_d   = write_valid_q;
        write_last_d    = write_last_q;
        read_ready_d    = read_ready_q;

        case (state_q)
            S_CMD_ISSUE, S_ADDR_ISSUE: step_mask = 8'h40;
            S_DATA_OUT:                step_mask = 8'h20;
            S_DATA_IN:                 step_mask = 8'h10;
            default:                   step_mask = 8'h00;
        endcase

        // The request bit is held until the ACG takes it once; done pulses only count afterwards.
        if (!launched_q && ((acg_command_q & step_mask) != 8'h00) && acg_ready) begin
            launched_d    = 1'b1;
            acg_command_d = 8'h00;
        end
        step_done = launched_q && ((acg.iACG_LastStep & step_mask) != 8'h00);

        case (state_q)
            S_RESET: state_d = S_READY;

            S_READY: begin
                if (oStart) begin
                    get_mode_d     = (iOpcode == GetCommandID);
                    feature_addr_d = iFeatureAddr;
                    wdata_sr_d     = iFeatureData;
                    target_way_d   = iWaySelect;
                    cmd_ready_d    = 1'b0;
                    launched_d     = 1'b0;
                    captured_d     = 1'b0;
                    capture_d      = '0;
                    acg_command_d  = 8'h40;
                    ca_select_d    = 1'b1;
                    num_of_data_d  = 16'd1;
                    ca_data_d      = {(iOpcode == GetCommandID) ? 8'hEE : 8'hEF, 32'h0};
                    state_d        = S_CMD_ISSUE;
                end
            end

            S_CMD_ISSUE: begin
                if (step_done) begin
                    launched_d    = 1'b0;
                    acg_command_d = 8'h40;
                    ca_select_d   = 1'b0;
                    num_of_data_d = 16'd1;
                    ca_data_d     = {feature_addr_q, 32'h0};
                    state_d       = S_ADDR_ISSUE;
                end
            end

            S_ADDR_ISSUE: begin
                if (step_done) begin
                    launched_d = 1'b0;
                    if (get_mode_q) begin
                        rb_cnt_d = '0;
                        state_d  = S_WAIT_RB_LOW;
                    end else begin
                        acg_command_d = 8'h20;
                        num_of_data_d = 16'(2 * ParamWords);
                        write_valid_d = 1'b1;
                        write_last_d  = (ParamWords == 1);
                        word_cnt_d    = '0;
                        state_d       = S_DATA_OUT;
                    end
                end
            end

            S_DATA_OUT: begin
                if (write_valid_q && acg.iACG_WriteReady) begin
                    if (word_cnt_q == CntW'(ParamWords - 1)) begin
                        write_valid_d = 1'b0;
                        write_last_d  = 1'b0;
                    end else begin
                        word_cnt_d   = word_cnt_q + 1'b1;
                        wdata_sr_d   = wdata_sr_q << 16;
                        write_last_d = (word_cnt_q == CntW'(ParamWords - 2));
                    end
                end
                if (step_done) begin
                    write_valid_d = 1'b0;
                    write_last_d  = 1'b0;
                    rb_cnt_d      = '0;
                    state_d       = S_WAIT_RB_LOW;
                end
            end

            // A busy pulse shorter than the sampling pipeline can be missed; the timeout covers it.
            S_WAIT_RB_LOW: begin
                if (!way_rb_q || (rb_cnt_q == RbW'(RBLowTimeout - 1))) begin
                    state_d = S_WAIT_RB_HIGH;
                end else begin
                    rb_cnt_d = rb_cnt_q + 1'b1;
                end
            end

            S_WAIT_RB_HIGH: begin
                if (way_rb_q) begin
                    if (get_mode_q) begin
                        launched_d    = 1'b0;
                        acg_command_d = 8'h10;
                        num_of_data_d = 16'(2 * ParamWords);
                        read_ready_d  = 1'b1;
                        word_cnt_d    = '0;
                        state_d       = S_DATA_IN;
                    end else begin
                        last_step_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            S_DATA_IN: begin
                if (read_ready_q && acg.iACG_ReadValid && !captured_q) begin
                    capture_d = capture_shift;
                    if ((word_cnt_q == CntW'(ParamWords - 1)) || acg.iACG_ReadLast) begin
                        feature_data_d  = capture_shift;
                        feature_valid_d = 1'b1;
                        captured_d      = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                if (step_done) begin
                    read_ready_d = 1'b0;
                    last_step_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                cmd_ready_d  = 1'b1;
                target_way_d = '0;
                state_d      = S_READY;
            end

            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q         <= S_RESET;
            cmd_ready_q     <= 1'b1;
            get_mode_q      <= 1'b0;
            feature_addr_q  <= '0;
            wdata_sr_q      <= '0;
            word_cnt_q      <= '0;
            launched_q      <= 1'b0;
            rb_cnt_q        <= '0;
            rb_sample_q     <= '0;
            way_rb_q        <= 1'b0;
            capture_q       <= '0;
            captured_q      <= 1'b0;
            feature_data_q  <= '0;
            feature_valid_q <= 1'b0;
            last_step_q     <= 1'b0;
            acg_command_q   <= '0;
            target_way_q    <= '0;
            num_of_data_q   <= '0;
            ca_select_q     <= 1'b1;
            ca_data_q       <= '0;
            write_valid_q   <= 1'b0;
            write_last_q    <= 1'b0;
            read_ready_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            get_mode_q      <= get_mode_d;
            feature_addr_q  <= feature_addr_d;
            wdata_sr_q      <= wdata_sr_d;
            word_cnt_q      <= word_cnt_d;
            launched_q      <= launched_d;
            rb_cnt_q        <= rb_cnt_d;
            rb_sample_q     <= rb_sample_d;
            way_rb_q        <= way_rb_d;
            capture_q       <= capture_d;
            captured_q      <= captured_d;
            feature_data_q  <= feature_data_d;
            feature_valid_q <= feature_valid_d;
            last_step_q     <= last_step_d;
            acg_command_q   <= acg_command_d;
            target_way_q    <= target_way_d;
            num_of_data_q   <= num_of_data_d;
            ca_select_q     <= ca_select_d;
            ca_data_q       <= ca_data_d;
            write_valid_q   <= write_valid_d;
            write_last_q    <= write_last_d;
            read_ready_q    <= read_ready_d;
        end
    end

endmodule

// File: tb/tb_nfc_command_feature.sv
`timescale 1ns/1ps
// Scoreboard bench for nfc_command_feature: the stimulus acts as the ACG engine and
// queues the expected CA launches, write words, read results and completion pulses.
module tb_nfc_command_feature;

    localparam logic [5:0] SetId = 6'b000010;
    localparam logic [5:0] GetId = 6'b000011;

    typedef enum logic [1:0] {EV_CA, EV_WR, EV_FV, EV_LS} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [63:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        iReset;
    logic [5:0]  iOpcode;
    logic        iCMDValid;
    logic        oCMDReady;
    logic [3:0]  iWaySelect;
    logic [7:0]  iFeatureAddr;
    logic [31:0] iFeatureData;
    logic [31:0] oFeatureData;
    logic        oFeatureValid;
    logic        oStart;
    logic        oLastStep;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    nfc_command_feature_if #(.NumberOfWays(4)) acg_if ();

    nfc_command_feature #(
        .NumberOfWays(4),
        .SetCommandID(SetId),
        .GetCommandID(GetId),
        .ParamWords(2),
        .RBLowTimeout(64)
    ) dut (
        .iSystemClock (clk),
        .iReset       (iReset),
        .iOpcode      (iOpcode),
        .iCMDValid    (iCMDValid),
        .oCMDReady    (oCMDReady),
        .iWaySelect   (iWaySelect),
        .iFeatureAddr (iFeatureAddr),
        .iFeatureData (iFeatureData),
        .oFeatureData (oFeatureData),
        .oFeatureValid(oFeatureValid),
        .oStart       (oStart),
        .oLastStep    (oLastStep),
        .acg          (acg_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out, no event seen, required event within budget", name);
    endtask

    task automatic expectEvent(input ev_kind_e kind, input logic [63:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e kind, input logic [63:0] value);
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_%s: got %h, required no event", kind.name(), value);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.value !== value) begin
                fails++;
                $display("[TB] FAIL event_%s: got %s %h, required %s %h",
                         e.kind.name(), kind.name(), value, e.kind.name(), e.value);
            end
        end
    endtask

    // Monitor: samples on the falling edge, between the bench's drive points.
    always @(negedge clk) begin
        if (!iReset) begin
            if (acg_if.oACG_Command[6] && acg_if.iACG_Ready[6:0] == 7'h7F)
                observe(EV_CA, {7'h0, acg_if.oACG_CASelect, acg_if.oACG_NumOfData, acg_if.oACG_CAData});
            if (acg_if.oACG_WriteValid && acg_if.iACG_WriteReady)
                observe(EV_WR, 64'({acg_if.oACG_NumOfData, acg_if.oACG_TargetWay,
                                    acg_if.oACG_WriteLast, acg_if.oACG_WriteData}));
            if (oFeatureValid)
                observe(EV_FV, 64'(oFeatureData));
            if (oLastStep)
                observe(EV_LS, 64'(0));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [7:0] addr, input logic [31:0] data);
        checkOutput("cmd_ready_idle", 64'(oCMDReady), 64'(1));
        iOpcode      = op;
        iWaySelect   = 4'b0001;
        iFeatureAddr = addr;
        iFeatureData = data;
        iCMDValid    = 1'b1;
        #1;
        checkOutput("start_valid_opcode", 64'(oStart), 64'(1));
        cycle();
        iCMDValid = 1'b0;
        checkOutput("cmd_ready_busy", 64'(oCMDReady), 64'(0));
    endtask

    task automatic waitCmdBit(input int b, input string name);
        int n = 0;
        while (!acg_if.oACG_Command[b] && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) reportTimeout(name);
    endtask

    task automatic pulseLast(input int b);
        acg_if.iACG_LastStep = 8'(1 << b);
        cycle();
        acg_if.iACG_LastStep = 8'h00;
    endtask

    task automatic caStep(input string name);
        waitCmdBit(6, name);
        cycle();
        cycle();
        pulseLast(6);
    endtask

    task automatic dataOutStep(input bit stall, input logic [15:0] second_word);
        int n;
        waitCmdBit(5, "dout_request");
        for (int w = 0; w < 2; w++) begin
            if (stall && w == 1) begin
                for (int s = 0; s < 5; s++) begin
                    cycle();
                    checkOutput("stall_hold", 64'({acg_if.oACG_WriteValid, acg_if.oACG_WriteLast, acg_if.oACG_WriteData}),
                                64'({1'b1, 1'b1, second_word}));
                end
            end
            acg_if.iACG_WriteReady = 1'b1;
            n = 0;
            while (!acg_if.oACG_WriteValid && n < 50) begin
                cycle();
                n++;
            end
            if (n >= 50) reportTimeout("dout_word_valid");
            cycle();
            acg_if.iACG_WriteReady = 1'b0;
        end
        pulseLast(5);
    endtask

    task automatic rbPulse();
        acg_if.iACG_ReadyBusy = 4'h0;
        repeat (6) cycle();
        acg_if.iACG_ReadyBusy = 4'hF;
    endtask

    task automatic waitDone(input string name, input int budget, output int n);
        n = 0;
        while (!oLastStep && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) reportTimeout(name);
        else cycle();
    endtask

    task automatic runSet(input logic [7:0] addr, input logic [31:0] data, input bit stall,
                          input bit rb_pulse, output int done_cycles);
        expectEvent(EV_CA, {7'h0, 1'b1, 16'd1, 8'hEF, 32'h0});
        expectEvent(EV_CA, {7'h0, 1'b0, 16'd1, addr, 32'h0});
        expectEvent(EV_WR, 64'({16'd4, 4'b0001, 1'b0, data[31:16]}));
        expectEvent(EV_WR, 64'({16'd4, 4'b0001, 1'b1, data[15:0]}));
        expectEvent(EV_LS, 64'(0));
        applyStimulus(SetId, addr, data);
        caStep("set_cmd_request");
        caStep("set_addr_request");
        dataOutStep(stall, data[15:0]);
        if (rb_pulse) rbPulse();
        waitDone("set_done", 300, done_cycles);
        checkOutput("set_scoreboard_drained", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        iReset       = 1'b1;
        iOpcode      = 6'h0;
        iCMDValid    = 1'b0;
        iWaySelect   = 4'h0;
        iFeatureAddr = 8'h0;
        iFeatureData = 32'h0;
        acg_if.iACG_Ready      = 8'hFF;
        acg_if.iACG_LastStep   = 8'h00;
        acg_if.iACG_WriteReady = 1'b0;
        acg_if.iACG_ReadData   = 16'h0;
        acg_if.iACG_ReadLast   = 1'b0;
        acg_if.iACG_ReadValid  = 1'b0;
        acg_if.iACG_ReadyBusy  = 4'hF;
        repeat (3) cycle();

        checkOutput("reset_cmd_ready", 64'(oCMDReady), 64'(1));
        checkOutput("reset_acg_command", 64'(acg_if.oACG_Command), 64'(0));
        checkOutput("reset_ca_lines", 64'({acg_if.oACG_CASelect, acg_if.oACG_CAData}), 64'({1'b1, 40'h0}));
        checkOutput("reset_flags", 64'({oLastStep, oFeatureValid, acg_if.oACG_WriteValid,
                                        acg_if.oACG_WriteLast, acg_if.oACG_ReadReady}), 64'(0));
        checkOutput("reset_feature_data", 64'(oFeatureData), 64'(0));
        checkOutput("reset_way_count", 64'({acg_if.oACG_TargetWay, acg_if.oACG_NumOfData}), 64'(0));
        iReset = 1'b0;
        repeat (2) cycle();

        // Plain SET FEATURES.
        runSet(8'h01, 32'h1400_0000, 1'b0, 1'b1, cyc);

        // GET FEATURES with a two-word read.
        expectEvent(EV_CA, {7'h0, 1'b1, 16'd1, 8'hEE, 32'h0});
        expectEvent(EV_CA, {7'h0, 1'b0, 16'd1, 8'h80, 32'h0});
        expectEvent(EV_FV, 64'(32'hABCD_1234));
        expectEvent(EV_LS, 64'(0));
        applyStimulus(GetId, 8'h80, 32'hFFFF_FFFF);
        caStep("get_cmd_request");
        caStep("get_addr_request");
        rbPulse();
        waitCmdBit(4, "din_request");
        checkOutput("din_read_ready", 64'({acg_if.oACG_ReadReady, acg_if.oACG_NumOfData}), 64'({1'b1, 16'd4}));
        acg_if.iACG_ReadData  = 16'hABCD;
        acg_if.iACG_ReadValid = 1'b1;
        cycle();
        acg_if.iACG_ReadData  = 16'h1234;
        acg_if.iACG_ReadLast  = 1'b1;
        cycle();
        acg_if.iACG_ReadValid = 1'b0;
        acg_if.iACG_ReadLast  = 1'b0;
        pulseLast(4);
        waitDone("get_done", 300, cyc);
        checkOutput("get_feature_data_held", 64'(oFeatureData), 64'(32'hABCD_1234));
        checkOutput("get_scoreboard_drained", 64'(sb_q.size()), 64'(0));

        // SET with a five-cycle write stall between the two words.
        runSet(8'h02, 32'hBEEF_5A5A, 1'b1, 1'b1, cyc);

        // Busy never seen: the watchdog releases WaitRBLow after 64 cycles.
        runSet(8'h03, 32'h0000_0001, 1'b0, 1'b0, cyc);
        checkOutput("rb_timeout_window", 64'(cyc >= 60 && cyc <= 70), 64'(1));

        // Reset in the middle of DATAOut, then a clean SET.
        expectEvent(EV_CA, {7'h0, 1'b1, 16'd1, 8'hEF, 32'h0});
        expectEvent(EV_CA, {7'h0, 1'b0, 16'd1, 8'h05, 32'h0});
        applyStimulus(SetId, 8'h05, 32'h1111_2222);
        caStep("rst_cmd_request");
        caStep("rst_addr_request");
        waitCmdBit(5, "rst_dout_request");
        iReset = 1'b1;
        cycle();
        checkOutput("midreset_outputs", 64'({acg_if.oACG_Command, acg_if.oACG_WriteValid, oCMDReady}),
                    64'({8'h00, 1'b0, 1'b1}));
        iReset = 1'b0;
        repeat (3) cycle();
        checkOutput("midreset_ready", 64'(oCMDReady), 64'(1));
        checkOutput("midreset_scoreboard", 64'(sb_q.size()), 64'(0));
        runSet(8'h06, 32'hCAFE_0F0F, 1'b0, 1'b1, cyc);

        // Unknown opcode must be ignored.
        iOpcode   = 6'b000111;
        iCMDValid = 1'b1;
        #1;
        checkOutput("bad_opcode_start", 64'(oStart), 64'(0));
        repeat (5) cycle();
        checkOutput("bad_opcode_idle", 64'({oCMDReady, acg_if.oACG_Command}), 64'({1'b1, 8'h00}));
        iCMDValid = 1'b0;

        repeat (5) cycle();
        checkOutput("final_scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
